iq_stream_pacer: RTL

- Drains the IQ sample FIFO written by the SPI command controller.
- Pairs consecutive bytes into I/Q samples and presents one sample per programmable sample period to the DAC/modulator datapath.
- Owns the FIFO read side: prefill gating, fixed-rate pacing, I/Q byte alignment, and underrun detection and recovery.

---
 rtl/iq_pkg.sv | 23 ++
 rtl/iq_rate_tick.sv | 37 +++
 rtl/iq_stream_pacer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared types and constants for the IQ stream pacer slice.
package iq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFILL,
      ST_RUN,
      ST_FETCH_I,
      ST_FETCH_Q,
      ST_EMIT
   } iq_state_t;

   // What the current fetch slot will emit: a real FIFO pair, a prefill zero or an underrun zero.
   typedef enum logic [1:0] {
      FK_REAL,
      FK_ZERO,
      FK_UNDER
   } fetch_kind_t;

   localparam int MIN_DIV     = 3;
   localparam int DEF_PREFILL = 64;

endpackage

// File: rtl/iq_rate_tick.sv
// Sample-period down-counter: reloads max(rate_div, MIN_DIV) on load or tick, counts while run.
module iq_rate_tick
   import iq_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             load,
   input  logic [DIV_W-1:0] rate_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] eff_div;

   always_comb begin
      eff_div = rate_div;
      if (rate_div < DIV_W'(MIN_DIV)) begin
         eff_div = DIV_W'(MIN_DIV);
      end
   end

   assign tick = run && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load || tick) begin
         cnt <= eff_div;
      end else if (run) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/iq_stream_pacer.sv
// FIFO read-side pacer: prefill gating, fixed-rate I/Q pair fetch, underrun detection and recovery.
module iq_stream_pacer
   import iq_pkg::*;
#(
   parameter int DIV_W   = 16,
   parameter int CNT_W   = 12,
   parameter int PREFILL = DEF_PREFILL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] rate_div,
   input  logic [7:0]       fifo_rd_data,
   input  logic [CNT_W-1:0] fifo_used,
   output logic             fifo_rd,
   output logic [7:0]       i_out,
   output logic [7:0]       q_out,
   output logic             iq_valid,
   output logic             streaming,
   output logic             underrun,
   input  logic             underrun_clr
);

   iq_state_t   state, state_n;
   fetch_kind_t kind, kind_n;

   logic       tick;
   logic       load;
   logic       run;
   logic       cap_i;
   logic       emit;
   logic       to_idle;
   logic       fill_ok;
   logic       pair_ok;
   logic [7:0] i_byte;

   assign run     = (state != ST_IDLE);
   assign fill_ok = (fifo_used >= CNT_W'(PREFILL));
   assign pair_ok = (fifo_used >= CNT_W'(2));
   assign to_idle = run && (state_n == ST_IDLE);

   iq_rate_tick #(
      .DIV_W (DIV_W)
   ) u_rate_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .load     (load),
      .rate_div (rate_div),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         kind  <= FK_ZERO;
      end else begin
         state <= state_n;
         kind  <= kind_n;
      end
   end

   // Zero and underrun slots walk the same FETCH_I/FETCH_Q/EMIT path without reading,
   // so every sample leaves exactly three cycles after its tick.
   always_comb begin
      state_n = state;
      kind_n  = kind;
      load    = 1'b0;
      fifo_rd = 1'b0;
      cap_i   = 1'b0;
      emit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               load    = 1'b1;
               state_n = ST_PREFILL;
            end
         end
         ST_PREFILL, ST_RUN: begin
            if (!enable) begin
               state_n = ST_IDLE;
            end else if (tick) begin
               state_n = ST_FETCH_I;
               if ((state == ST_PREFILL) ? fill_ok : pair_ok) begin
                  kind_n  = FK_REAL;
                  fifo_rd = 1'b1;
               end else if (state == ST_PREFILL) begin
                  kind_n = FK_ZERO;
               end else begin
                  kind_n = FK_UNDER;
               end
            end
         end
         ST_FETCH_I: begin
            fifo_rd = (kind == FK_REAL);
            cap_i   = (kind == FK_REAL);
            state_n = ST_FETCH_Q;
         end
         ST_FETCH_Q: begin
            emit    = 1'b1;
            state_n = ST_EMIT;
         end
         ST_EMIT: begin
            if (!enable) begin
               state_n = ST_IDLE;
            end else if (kind == FK_REAL) begin
               state_n = ST_RUN;
            end else begin
               state_n = ST_PREFILL;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_byte    <= '0;
         i_out     <= '0;
         q_out     <= '0;
         iq_valid  <= 1'b0;
         streaming <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         iq_valid <= emit;
         if (cap_i) begin
            i_byte <= fifo_rd_data;
         end
         if (emit) begin
            if (kind == FK_REAL) begin
               i_out     <= i_byte;
               q_out     <= fifo_rd_data;
               streaming <= 1'b1;
            end else begin
               i_out <= '0;
               q_out <= '0;
               if (kind == FK_UNDER) begin
                  streaming <= 1'b0;
               end
            end
         end else if (to_idle) begin
            i_out     <= '0;
            q_out     <= '0;
            streaming <= 1'b0;
         end
         // A set on the same edge as a clear wins.
         if (emit && (kind == FK_UNDER)) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule
